regslv_access_ctrl: RTL and testbench
=====================================

REGSLV_ACCESS_CTRL -- requirements
Module: regslv_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bus and field-bundle data width.
REQ-003 SHALL have parameter REG_NUM, default 8, number of decoded registers.
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of register 0.
REQ-005 SHALL have ports, in this order:
- clk  input  1  sole clock.
- rst  input  1  synchronous reset, active-high.
- req_vld  input  1  bus request valid.
- req_rdy  output  1  request accepted when high with req_vld.
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  write data.
- ack_vld  output  1  response valid.
- ack_rdy  input  1  response consumed when high with ack_vld.
- ack_rdata  output  DATA_WIDTH  read data.
- ack_err  output  1  decode error.
- sw_wr  output  REG_NUM  one-hot write strobe per register.
- sw_rd  output  REG_NUM  one-hot read strobe per register.
- sw_wr_data  output  DATA_WIDTH  write data broadcast to all registers.
- reg_rd_data  input  REG_NUM*DATA_WIDTH  current register values; register i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-006 SHALL implement FSM states IDLE, STROBE, RESP.
REQ-007 IDLE: req_rdy=1; on req_vld SHALL register req_wr, req_addr and req_wdata, then go to STROBE.
REQ-008 STROBE: req_rdy=0, always lasting exactly 1 cycle, then go to RESP.
REQ-009 Decode: off = req_addr - BASE_ADDR, computed in ADDR_WIDTH-bit unsigned arithmetic.
- Hit when off[1:0]==0 and (off>>2) < REG_NUM.
- Otherwise error: includes wrap-around when req_addr < BASE_ADDR.
REQ-010 STROBE on hit write: sw_wr[idx]=1 for exactly that cycle; sw_wr_data = registered wdata.
REQ-011 STROBE on hit read: sw_rd[idx]=1 for exactly that cycle; reg_rd_data slice idx SHALL be captured in the same cycle, i.e. the value before any read side-effect.
REQ-012 STROBE on error: no strobe asserted; ack_err SHALL be set; captured rdata=0.
REQ-013 Write response: ack_rdata=0.
REQ-014 RESP: ack_vld=1.
- ack_rdata and ack_err SHALL be held stable until ack_vld&&ack_rdy, then return to IDLE.
REQ-015 Latency: acceptance at cycle N, strobe at N+1, ack_vld at N+2; with ack_rdy held high, next req_rdy at N+3.
REQ-016 At most one transaction in flight; req_rdy SHALL be 0 in STROBE and RESP.
REQ-017 sw_wr and sw_rd SHALL never both be nonzero; each SHALL be 0 outside STROBE.
REQ-018 sw_wr_data SHALL be 0 when no write strobe is asserted.

Reset
REQ-019 rst=1 at a clock edge SHALL force IDLE, overriding any in-flight transaction, which is dropped with no response.
REQ-020 Reset values: req_rdy=0 while rst is high, then 1 in IDLE; ack_vld=0; ack_rdata=0; ack_err=0; sw_wr=0; sw_rd=0; sw_wr_data=0.
REQ-021 A strobe that would have been issued in the reset cycle SHALL be suppressed.

Structure
REQ-022 State enum (IDLE/STROBE/RESP) SHALL live in the shared register package next to the existing SW_* and onread/onwrite type constants.
REQ-023 Address decode SHALL be a sub-module regslv_addr_dec.
- Inputs: offset.
- Outputs: hit, one-hot sel[REG_NUM].
- Purely combinational.
REQ-024 Read-data selection SHALL reuse the team's existing priority_mux, driven by the one-hot sel.

Verification
REQ-025 Hit write: BASE_ADDR=0x100, write 0x108 with data 0xDEADBEEF -> sw_wr=0x04 for 1 cycle at N+1, sw_wr_data=0xDEADBEEF, ack_vld at N+2, ack_err=0.
REQ-026 Read with clear-on-read: register 3 = 0x5A, read 0x10C -> sw_rd=0x08 for 1 cycle, ack_rdata=0x5A even though the register clears the next cycle.
REQ-027 Error cases -> no strobe, ack_err=1, ack_rdata=0:
- Unaligned 0x102.
- Out of range 0x120.
- Below-base 0x0FC.
REQ-028 Backpressure: ack_rdy=0 for 5 cycles -> ack_vld and ack_rdata stable; req_rdy=0 throughout; a new req_vld is not accepted.
REQ-029 Reset mid-operation: rst asserted in STROBE -> no sw_wr pulse, no ack; req_rdy=1 the cycle after rst deasserts.
REQ-030 Back-to-back transactions with ack_rdy=1 -> one transaction per 3 cycles; strobes never overlap.

Source files
------------

// File: rtl/regslv_access_ctrl_pkg.sv
// Shared register-slave package: software access types, side-effect types and
// the bus access FSM state encoding.
package regslv_access_ctrl_pkg;

    typedef enum logic [1:0] {
        SW_RW = 2'd0,
        SW_RO = 2'd1,
        SW_WO = 2'd2
    } sw_access_e;

    typedef enum logic [1:0] {
        ONREAD_NONE = 2'd0,
        ONREAD_RCLR = 2'd1,
        ONREAD_RSET = 2'd2
    } onread_e;

    typedef enum logic [1:0] {
        ONWRITE_NONE  = 2'd0,
        ONWRITE_WOCLR = 2'd1,
        ONWRITE_WOSET = 2'd2
    } onwrite_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        RESP   = 2'd2
    } acc_state_e;

    localparam int unsigned BYTE_OFFSET_W = 2;

endpackage

// File: rtl/priority_mux.sv
// One-hot/priority read mux: lowest set select index wins, zero when none set.
module priority_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 8
) (
    input  logic [N-1:0]       sel,
    input  logic [N*WIDTH-1:0] data,
    output logic [WIDTH-1:0]   out
);

    always_comb begin
        out = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (sel[i]) begin
                out = data[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/regslv_addr_dec.sv
// Combinational register address decode from a base-relative byte offset.
module regslv_addr_dec
    import regslv_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned REG_NUM    = 8
) (
    input  logic [ADDR_WIDTH-1:0] offset,
    output logic                  hit,
    output logic [REG_NUM-1:0]    sel
);

    localparam int unsigned IDX_W = ADDR_WIDTH - BYTE_OFFSET_W;

    logic [IDX_W-1:0] idx;

    assign idx = offset[ADDR_WIDTH-1:BYTE_OFFSET_W];

    always_comb begin
        hit = (offset[BYTE_OFFSET_W-1:0] == '0) && (32'(idx) < 32'(REG_NUM));
        sel = '0;
        for (int i = 0; i < int'(REG_NUM); i++) begin
            sel[i] = hit && (32'(idx) == 32'(i));
        end
    end

endmodule

// File: rtl/regslv_access_ctrl.sv
// Register-slave bus access controller: accepts one request at a time, issues a
// single-cycle field strobe, then holds the response until it is consumed.
module regslv_access_ctrl
    import regslv_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_NUM    = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_vld,
    output logic                          req_rdy,
    input  logic                          req_wr,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0]         req_wdata,
    output logic                          ack_vld,
    input  logic                          ack_rdy,
    output logic [DATA_WIDTH-1:0]         ack_rdata,
    output logic                          ack_err,
    output logic [REG_NUM-1:0]            sw_wr,
    output logic [REG_NUM-1:0]            sw_rd,
    output logic [DATA_WIDTH-1:0]         sw_wr_data,
    input  logic [REG_NUM*DATA_WIDTH-1:0] reg_rd_data
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    acc_state_e state_q, state_d;

    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  hit;
    logic [REG_NUM-1:0]    sel;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  strobe_en;

    assign offset = addr_q - BASE;

    regslv_addr_dec #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .REG_NUM   (REG_NUM)
    ) u_addr_dec (
        .offset(offset),
        .hit   (hit),
        .sel   (sel)
    );

    priority_mux #(
        .WIDTH(DATA_WIDTH),
        .N    (REG_NUM)
    ) u_rd_mux (
        .sel (sel),
        .data(reg_rd_data),
        .out (sel_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes are gated by rst so a reset landing in STROBE suppresses the pulse.
    always_comb begin
        state_d    = state_q;
        req_rdy    = 1'b0;
        strobe_en  = 1'b0;
        sw_wr      = '0;
        sw_rd      = '0;
        sw_wr_data = '0;
        case (state_q)
            IDLE: begin
                req_rdy = !rst;
                if (req_vld) begin
                    state_d = STROBE;
                end
            end
            STROBE: begin
                strobe_en = !rst;
                state_d   = RESP;
            end
            RESP: begin
                if (ack_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (strobe_en && hit) begin
            if (wr_q) begin
                sw_wr      = sel;
                sw_wr_data = wdata_q;
            end else begin
                sw_rd = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (req_vld && req_rdy) begin
            wr_q    <= req_wr;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Read data is captured in the strobe cycle, before any read side-effect lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_vld   <= 1'b0;
            ack_rdata <= '0;
            ack_err   <= 1'b0;
        end else if (state_q == STROBE) begin
            ack_vld   <= 1'b1;
            ack_err   <= !hit;
            ack_rdata <= (hit && !wr_q) ? sel_rdata : '0;
        end else if (state_q == RESP && ack_rdy) begin
            ack_vld   <= 1'b0;
            ack_rdata <= '0;
            ack_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regslv_access_ctrl.sv
// Self-checking bench for regslv_access_ctrl with a small register-block model
// attached to the field interface (register 3 clears on read).
module tb_regslv_access_ctrl;

    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 32;
    localparam int unsigned RN   = 8;
    localparam int unsigned BASE = 32'h100;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_vld;
    logic           req_rdy;
    logic           req_wr;
    logic [AW-1:0]  req_addr;
    logic [DW-1:0]  req_wdata;
    logic           ack_vld;
    logic           ack_rdy;
    logic [DW-1:0]  ack_rdata;
    logic           ack_err;
    logic [RN-1:0]  sw_wr;
    logic [RN-1:0]  sw_rd;
    logic [DW-1:0]  sw_wr_data;
    logic [RN*DW-1:0] reg_rd_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int last_acc = 0;

    logic [DW-1:0] env_regs [RN];
    logic [DW-1:0] mdl [RN];

    regslv_access_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .REG_NUM   (RN),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ack_vld    (ack_vld),
        .ack_rdy    (ack_rdy),
        .ack_rdata  (ack_rdata),
        .ack_err    (ack_err),
        .sw_wr      (sw_wr),
        .sw_rd      (sw_rd),
        .sw_wr_data (sw_wr_data),
        .reg_rd_data(reg_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input int i);
        return (i == 3) ? 32'h0000_005A : (32'hC0DE_0000 | 32'(i));
    endfunction

    // Register block: plain RW fields, register 3 cleared by a read strobe.
    always @(posedge clk) begin
        for (int i = 0; i < int'(RN); i++) begin
            if (rst)
                env_regs[i] <= init_val(i);
            else if (sw_wr[i])
                env_regs[i] <= sw_wr_data;
            else if (i == 3 && sw_rd[i])
                env_regs[i] <= '0;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(RN); i++)
            reg_rd_data[i*DW +: DW] = env_regs[i];
    end

    task automatic reset_model();
        for (int i = 0; i < int'(RN); i++) mdl[i] = init_val(i);
    endtask

    // Reference decode from plain arithmetic on the byte address.
    task automatic ref_decode(input logic [AW-1:0] addr, output bit hit, output int idx);
        int off;
        off = (int'(addr) - int'(BASE)) & 32'hFFFF;
        hit = ((off % 4) == 0) && ((off / 4) < int'(RN));
        idx = hit ? off / 4 : 0;
    endtask

    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bit hit; int idx; int w;
        logic [RN-1:0] exp_wr, exp_rd;
        logic [DW-1:0] exp_data, exp_rdata;
        ref_decode(addr, hit, idx);
        exp_wr    = (hit && wr)  ? RN'(1 << idx) : '0;
        exp_rd    = (hit && !wr) ? RN'(1 << idx) : '0;
        exp_data  = (hit && wr)  ? data : '0;
        exp_rdata = (hit && !wr) ? mdl[idx] : '0;
        w = 0;
        while (req_rdy !== 1'b1 && w < 10) begin
            @(posedge clk); #1; w++;
        end
        n_cmp++;
        if (req_rdy !== 1'b1) begin
            n_bad++; $display("FAIL req_rdy_wait: got %b expected 1", req_rdy);
            return;
        end
        req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = data;
        last_acc = cyc;
        @(posedge clk); #1;
        req_vld = 1'b0;
        n_cmp++;
        if (sw_wr !== exp_wr || sw_rd !== exp_rd || sw_wr_data !== exp_data) begin
            n_bad++;
            $display("FAIL strobe @%h: got wr=%h rd=%h d=%h expected wr=%h rd=%h d=%h",
                     addr, sw_wr, sw_rd, sw_wr_data, exp_wr, exp_rd, exp_data);
        end
        n_cmp++;
        if (req_rdy !== 1'b0 || ack_vld !== 1'b0) begin
            n_bad++; $display("FAIL strobe_ctl: got rdy=%b vld=%b expected 0 0", req_rdy, ack_vld);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (ack_vld !== 1'b1 || ack_err !== !hit || ack_rdata !== exp_rdata) begin
            n_bad++;
            $display("FAIL resp @%h: got vld=%b err=%b rdata=%h expected 1 %b %h",
                     addr, ack_vld, ack_err, ack_rdata, !hit, exp_rdata);
        end
        n_cmp++;
        if (sw_wr !== '0 || sw_rd !== '0 || req_rdy !== 1'b0) begin
            n_bad++; $display("FAIL resp_quiet: got wr=%h rd=%h rdy=%b expected 0 0 0", sw_wr, sw_rd, req_rdy);
        end
        if (hit && wr) mdl[idx] = data;
        if (hit && !wr && idx == 3) mdl[idx] = '0;
        if (ack_rdy !== 1'b1) return;
        @(posedge clk); #1;
        n_cmp++;
        if (ack_vld !== 1'b0 || req_rdy !== 1'b1) begin
            n_bad++; $display("FAIL after_ack: got vld=%b rdy=%b expected 0 1", ack_vld, req_rdy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; ack_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_model();
        n_cmp++;
        if (req_rdy !== 1'b0 || ack_vld !== 1'b0 || ack_rdata !== '0 || ack_err !== 1'b0 ||
            sw_wr !== '0 || sw_rd !== '0 || sw_wr_data !== '0) begin
            n_bad++;
            $display("FAIL reset_vals: got rdy=%b vld=%b rd=%h err=%b wr=%h rs=%h wd=%h expected all 0",
                     req_rdy, ack_vld, ack_rdata, ack_err, sw_wr, sw_rd, sw_wr_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (req_rdy !== 1'b1) begin
            n_bad++; $display("FAIL reset_rdy: got %b expected 1", req_rdy);
        end
    endtask

    task automatic test_hit_write();
        run_txn(1'b1, 16'h0108, 32'hDEADBEEF);
    endtask

    task automatic test_read_clear();
        run_txn(1'b0, 16'h010C, '0);
        run_txn(1'b0, 16'h010C, '0);
        run_txn(1'b0, 16'h0108, '0);
    endtask

    task automatic test_errors();
        run_txn(1'b1, 16'h0102, 32'h1111_1111);
        run_txn(1'b0, 16'h0120, '0);
        run_txn(1'b0, 16'h00FC, '0);
        run_txn(1'b1, 16'h00FC, 32'h2222_2222);
        run_txn(1'b0, 16'h011C, '0);
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        ack_rdy = 1'b0;
        run_txn(1'b0, 16'h0104, '0);
        held = mdl[1];
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 16'h0100; req_wdata = 32'hBAD0_BAD0;
        repeat (5) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ack_vld !== 1'b1 || ack_rdata !== held || req_rdy !== 1'b0 || sw_wr !== '0) begin
                n_bad++;
                $display("FAIL bp_hold: got vld=%b rdata=%h rdy=%b wr=%h expected 1 %h 0 0",
                         ack_vld, ack_rdata, req_rdy, sw_wr, held);
            end
        end
        req_vld = 1'b0; ack_rdy = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (ack_vld !== 1'b0 || req_rdy !== 1'b1) begin
            n_bad++; $display("FAIL bp_release: got vld=%b rdy=%b expected 0 1", ack_vld, req_rdy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (sw_wr !== '0 || ack_vld !== 1'b0) begin
            n_bad++; $display("FAIL bp_no_accept: got wr=%h vld=%b expected 0 0", sw_wr, ack_vld);
        end
        run_txn(1'b0, 16'h0100, '0);
    endtask

    task automatic test_reset_mid();
        run_txn(1'b1, 16'h0110, 32'h1234_5678);
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 16'h0104; req_wdata = 32'hFEED_F00D;
        @(posedge clk); #1;
        req_vld = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (sw_wr !== '0 || sw_wr_data !== '0 || req_rdy !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_strobe: got wr=%h wd=%h rdy=%b expected 0 0 0", sw_wr, sw_wr_data, req_rdy);
        end
        @(posedge clk); #1;
        reset_model();
        n_cmp++;
        if (ack_vld !== 1'b0 || req_rdy !== 1'b0 || sw_wr !== '0) begin
            n_bad++; $display("FAIL mid_rst_hold: got vld=%b rdy=%b wr=%h expected 0 0 0", ack_vld, req_rdy, sw_wr);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (req_rdy !== 1'b1 || ack_vld !== 1'b0 || sw_wr !== '0) begin
            n_bad++; $display("FAIL mid_rst_after: got rdy=%b vld=%b wr=%h expected 1 0 0", req_rdy, ack_vld, sw_wr);
        end
        run_txn(1'b0, 16'h0110, '0);
        run_txn(1'b0, 16'h0104, '0);
    endtask

    task automatic test_random();
        logic [AW-1:0] addr;
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: addr = AW'(BASE + 4 * $urandom_range(0, RN - 1));
                3:       addr = AW'(BASE + 4 * $urandom_range(0, RN - 1) + $urandom_range(1, 3));
                4:       addr = AW'(BASE + 4 * RN + 4 * $urandom_range(0, 64));
                default: addr = AW'($urandom_range(0, BASE - 1));
            endcase
            run_txn(1'($urandom_range(0, 1)), addr, $urandom());
        end
    endtask

    task automatic test_back_to_back();
        int prev;
        run_txn(1'b1, 16'h0118, $urandom());
        prev = last_acc;
        for (int t = 0; t < 20; t++) begin
            run_txn(1'($urandom_range(0, 1)), AW'(BASE + 4 * $urandom_range(0, RN - 1)), $urandom());
            n_cmp++;
            if (last_acc - prev !== 3) begin
                n_bad++; $display("FAIL b2b_cadence: got %0d cycles expected 3", last_acc - prev);
            end
            prev = last_acc;
        end
    endtask

    initial begin
        test_reset();
        test_hit_write();
        test_read_clear();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
